// File: rtl/phy_lane_scheduler.sv
// Four-lane byte scheduler: per-lane 4-deep FIFOs drained round-robin into one registered output.
// Optional LANE_TAG_EN adds the laneOut port carrying the lane of the byte on dataOut.
module phy_lane_scheduler (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] dataIn0,
  input  logic [7:0] dataIn1,
  input  logic [7:0] dataIn2,
  input  logic [7:0] dataIn3,
  input  logic       validIn0,
  input  logic       validIn1,
  input  logic       validIn2,
  input  logic       validIn3,
  output logic       readyOut0,
  output logic       readyOut1,
  output logic       readyOut2,
  output logic       readyOut3,
  input  logic       readyIn,
  output logic [7:0] dataOut,
  output logic       validOut,
  output logic       active,
  output logic [3:0] overflow
`ifdef LANE_TAG_EN
  ,
  output logic [1:0] laneOut
`endif
);

  localparam logic [7:0] IDLE_SYMBOL = 8'hBC;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  state_t          stateNext;
  logic [1:0]      ptr;
  logic [3:0][7:0] dataInVec;
  logic [3:0][7:0] headData;
  logic [3:0]      validInVec;
  logic [3:0]      full;
  logic [3:0]      nonEmpty;
  logic [3:0]      push;
  logic [3:0]      pop;
  logic            loadEn;
  logic            grantValid;
  logic [1:0]      grantLane;
  logic [1:0]      searchIdx;

  assign dataInVec  = {dataIn3, dataIn2, dataIn1, dataIn0};
  assign validInVec = {validIn3, validIn2, validIn1, validIn0};

  assign readyOut0 = ~full[0];
  assign readyOut1 = ~full[1];
  assign readyOut2 = ~full[2];
  assign readyOut3 = ~full[3];

  // Push is gated by the registered full flag only, so a same-cycle pop never frees room for it.
  assign push   = validInVec & ~full;
  assign loadEn = ~validOut | readyIn;
  assign pop    = (loadEn && grantValid) ? (4'b0001 << grantLane) : 4'b0000;

  for (genvar n = 0; n < 4; n++) begin : gLane
    logic [7:0] mem [4];
    logic [2:0] count;
    logic [1:0] rdPtr;
    logic [1:0] wrPtr;

    always_ff @(posedge clk_4f) begin
      if (reset) begin
        count <= 3'd0;
        rdPtr <= 2'd0;
        wrPtr <= 2'd0;
      end else begin
        if (push[n]) begin
          mem[wrPtr] <= dataInVec[n];
          wrPtr      <= wrPtr + 2'd1;
        end
        if (pop[n]) begin
          rdPtr <= rdPtr + 2'd1;
        end
        case ({push[n], pop[n]})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
    end

    assign full[n]     = (count == 3'd4);
    assign nonEmpty[n] = (count != 3'd0);
    assign headData[n] = mem[rdPtr];
  end

  // First non-empty lane at or after ptr, wrapping modulo 4.
  always_comb begin
    grantValid = 1'b0;
    grantLane  = ptr;
    searchIdx  = ptr;
    for (int i = 0; i < 4; i++) begin
      searchIdx = ptr + 2'(i);
      if (!grantValid && nonEmpty[searchIdx]) begin
        grantValid = 1'b1;
        grantLane  = searchIdx;
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      overflow <= 4'b0000;
    end else begin
      overflow <= overflow | (validInVec & full);
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (loadEn && grantValid)  stateNext = ACTIVE;
      ACTIVE:  if (loadEn && !grantValid) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign active = (state == ACTIVE);

  // Idle loads leave ptr (and laneOut) untouched so fairness resumes where it stopped.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      dataOut  <= IDLE_SYMBOL;
      validOut <= 1'b0;
      ptr      <= 2'd0;
`ifdef LANE_TAG_EN
      laneOut  <= 2'd0;
`endif
    end else if (loadEn) begin
      if (grantValid) begin
        dataOut  <= headData[grantLane];
        validOut <= 1'b1;
        ptr      <= grantLane + 2'd1;
`ifdef LANE_TAG_EN
        laneOut  <= grantLane;
`endif
      end else begin
        dataOut  <= IDLE_SYMBOL;
        validOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Self-checking bench for phy_lane_scheduler: vector table plus directed sequences, scoreboard on output.
// Define LANE_TAG_EN to also check laneOut.
module tb_phy_lane_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] dataIn0, dataIn1, dataIn2, dataIn3;
  logic       validIn0, validIn1, validIn2, validIn3;
  logic       readyOut0, readyOut1, readyOut2, readyOut3;
  logic       readyIn;
  logic [7:0] dataOut;
  logic       validOut;
  logic       active;
  logic [3:0] overflow;
`ifdef LANE_TAG_EN
  logic [1:0] laneOut;
`endif

  always #5 clk_4f = ~clk_4f;

  phy_lane_scheduler dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .dataIn0   (dataIn0),
    .dataIn1   (dataIn1),
    .dataIn2   (dataIn2),
    .dataIn3   (dataIn3),
    .validIn0  (validIn0),
    .validIn1  (validIn1),
    .validIn2  (validIn2),
    .validIn3  (validIn3),
    .readyOut0 (readyOut0),
    .readyOut1 (readyOut1),
    .readyOut2 (readyOut2),
    .readyOut3 (readyOut3),
    .readyIn   (readyIn),
    .dataOut   (dataOut),
    .validOut  (validOut),
    .active    (active),
    .overflow  (overflow)
`ifdef LANE_TAG_EN
    ,
    .laneOut   (laneOut)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] lane;
  } sbEntry_t;

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][7:0] din;
    logic [2:0]      expCount;
    logic [3:0][7:0] expData;
    logic [3:0][1:0] expLane;
  } vec_t;

  sbEntry_t sbQ[$];
  sbEntry_t monEntry;
  vec_t     vecs [5];
  int       vectors = 0;
  int       miscompares = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0][7:0] din);
    {validIn3, validIn2, validIn1, validIn0} = mask;
    dataIn0 = din[0];
    dataIn1 = din[1];
    dataIn2 = din[2];
    dataIn3 = din[3];
  endtask

  task automatic stepCycle();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    readyIn = 1'b0;
    applyStimulus(4'b0000, '0);
    sbQ.delete();
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic expectByte(input logic [7:0] data, input logic [1:0] lane);
    sbQ.push_back('{data: data, lane: lane});
  endtask

  // A byte leaves when validOut and readyIn are both high at the next rising edge.
  always @(negedge clk_4f) begin
    if (!reset && validOut && readyIn) begin
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedOutput: got %h, expected no valid byte", dataOut);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput("dataOut", dataOut, monEntry.data);
`ifdef LANE_TAG_EN
        checkOutput("laneOut", {6'b0, laneOut}, {6'b0, monEntry.lane});
`endif
      end
    end
  end

  initial begin
    #400000;
    miscompares++;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{mask: 4'b1111, din: {8'h88, 8'h99, 8'hAA, 8'hBB}, expCount: 3'd4,
                expData: {8'h88, 8'h99, 8'hAA, 8'hBB}, expLane: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{mask: 4'b0101, din: {8'h44, 8'h33, 8'h22, 8'h11}, expCount: 3'd2,
                expData: {8'h00, 8'h00, 8'h33, 8'h11}, expLane: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[2] = '{mask: 4'b1000, din: {8'h04, 8'h03, 8'h02, 8'h01}, expCount: 3'd1,
                expData: {8'h00, 8'h00, 8'h00, 8'h04}, expLane: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[3] = '{mask: 4'b1110, din: {8'hC3, 8'h3C, 8'hA5, 8'h5A}, expCount: 3'd3,
                expData: {8'h00, 8'hC3, 8'h3C, 8'hA5}, expLane: {2'd0, 2'd3, 2'd2, 2'd1}};
    vecs[4] = '{mask: 4'b1001, din: {8'h7F, 8'h80, 8'hFF, 8'h00}, expCount: 3'd2,
                expData: {8'h00, 8'h00, 8'h7F, 8'h00}, expLane: {2'd0, 2'd0, 2'd3, 2'd0}};

    // Reset values
    doReset();
    checkOutput("resetDataOut", dataOut, 8'hBC);
    checkOutput("resetValidOut", {7'b0, validOut}, 8'h00);
    checkOutput("resetActive", {7'b0, active}, 8'h00);
    checkOutput("resetOverflow", {4'b0, overflow}, 8'h00);
    checkOutput("resetReadyOut", {4'b0, readyOut3, readyOut2, readyOut1, readyOut0}, 8'h0F);
`ifdef LANE_TAG_EN
    checkOutput("resetLaneOut", {6'b0, laneOut}, 8'h00);
`endif

    // Single lane stream with one-cycle latency
    readyIn = 1'b1;
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hFF});
    expectByte(8'hFF, 2'd0);
    stepCycle();
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hEE});
    expectByte(8'hEE, 2'd0);
    stepCycle();
    checkOutput("latencyData", dataOut, 8'hFF);
    checkOutput("latencyValid", {7'b0, validOut}, 8'h01);
    checkOutput("activeHigh", {7'b0, active}, 8'h01);
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hDD});
    expectByte(8'hDD, 2'd0);
    stepCycle();
    applyStimulus(4'b0000, '0);
    stepCycle();
    stepCycle();
    checkOutput("singleIdleData", dataOut, 8'hBC);
    checkOutput("singleIdleValid", {7'b0, validOut}, 8'h00);
    checkOutput("singleIdleActive", {7'b0, active}, 8'h00);
    checkOutput("singleDrained", 8'(sbQ.size()), 8'h00);

    // Vector table: one-cycle burst on a lane mask, drained from ptr 0
    for (int v = 0; v < 5; v++) begin
      doReset();
      readyIn = 1'b1;
      applyStimulus(vecs[v].mask, vecs[v].din);
      for (int k = 0; k < int'(vecs[v].expCount); k++)
        expectByte(vecs[v].expData[k], vecs[v].expLane[k]);
      stepCycle();
      applyStimulus(4'b0000, '0);
      for (int c = 0; c < int'(vecs[v].expCount) + 2; c++)
        stepCycle();
      checkOutput("vecIdleValid", {7'b0, validOut}, 8'h00);
      checkOutput("vecIdleData", dataOut, 8'hBC);
      checkOutput("vecIdleActive", {7'b0, active}, 8'h00);
      checkOutput("vecDrained", 8'(sbQ.size()), 8'h00);
    end

    // ptr survives idle loads and wraps past lane 3
    doReset();
    readyIn = 1'b1;
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h21, 8'h00});
    expectByte(8'h21, 2'd1);
    stepCycle();
    applyStimulus(4'b0000, '0);
    stepCycle();
    stepCycle();
    stepCycle();
`ifdef LANE_TAG_EN
    checkOutput("laneOutHoldIdle", {6'b0, laneOut}, 8'h01);
`endif
    applyStimulus(4'b1111, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    expectByte(8'hD2, 2'd2);
    expectByte(8'hD3, 2'd3);
    expectByte(8'hD0, 2'd0);
    expectByte(8'hD1, 2'd1);
    stepCycle();
    applyStimulus(4'b0000, '0);
    for (int c = 0; c < 6; c++) stepCycle();
    checkOutput("ptrDrained", 8'(sbQ.size()), 8'h00);
    checkOutput("ptrIdleValid", {7'b0, validOut}, 8'h00);

    // Back-pressure and overflow on lane 2
    doReset();
    readyIn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0100, {8'h00, 8'(8'hC0 + i), 8'h00, 8'h00});
      if (i < 5) expectByte(8'(8'hC0 + i), 2'd2);
      stepCycle();
      checkOutput("bpReadyOut2", {7'b0, readyOut2}, (i < 4) ? 8'h01 : 8'h00);
      checkOutput("bpOverflow", {4'b0, overflow}, (i == 5) ? 8'h04 : 8'h00);
      if (i >= 1) checkOutput("bpHoldData", dataOut, 8'hC0);
    end
    applyStimulus(4'b0000, '0);
    stepCycle();
    stepCycle();
    checkOutput("bpHoldData2", dataOut, 8'hC0);
    checkOutput("bpHoldValid", {7'b0, validOut}, 8'h01);
    readyIn = 1'b1;
    for (int c = 0; c < 8; c++) stepCycle();
    checkOutput("bpDrained", 8'(sbQ.size()), 8'h00);
    checkOutput("bpOverflowSticky", {4'b0, overflow}, 8'h04);
    checkOutput("bpReadyRestored", {7'b0, readyOut2}, 8'h01);

    // All lanes kept non-empty: strict rotation, one byte per lane per round
    doReset();
    readyIn = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < 4; l++)
        expectByte(8'(8'h40 + 16 * l + r), 2'(l));
    for (int r = 0; r < 4; r++) begin
      applyStimulus(4'b1111, {8'(8'h70 + r), 8'(8'h60 + r), 8'(8'h50 + r), 8'(8'h40 + r)});
      stepCycle();
    end
    applyStimulus(4'b0000, '0);
    readyIn = 1'b1;
    for (int c = 0; c < 24 && sbQ.size() != 0; c++) stepCycle();
    checkOutput("rrDrained", 8'(sbQ.size()), 8'h00);
    checkOutput("rrNoOverflow", {4'b0, overflow}, 8'h00);
    stepCycle();
    checkOutput("rrIdleValid", {7'b0, validOut}, 8'h00);

    // Reset while a byte sits on dataOut under back-pressure
    doReset();
    readyIn = 1'b0;
    applyStimulus(4'b0100, {8'h00, 8'h77, 8'h00, 8'h00});
    stepCycle();
    applyStimulus(4'b0000, '0);
    stepCycle();
    checkOutput("preResetData", dataOut, 8'h77);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midResetData", dataOut, 8'hBC);
    checkOutput("midResetValid", {7'b0, validOut}, 8'h00);
    checkOutput("midResetActive", {7'b0, active}, 8'h00);
    checkOutput("midResetReady", {4'b0, readyOut3, readyOut2, readyOut1, readyOut0}, 8'h0F);
    readyIn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      checkOutput("postResetNoByte", {7'b0, validOut}, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
